// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset sequencer.
//   state_e : FSM state encoding (also exported on state_o for debug)
//   cls_e   : decode class latched in DECODE
//   dec_t   : combined decoder result (class + ALU op)
//   OPC_*   : major opcodes understood by the decoder
//   ALU_*   : 2-bit ALU select encodings
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_ILLEGAL
  } cls_e;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_IALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    cls_e       cls;
    logic [1:0] alu_op;
  } dec_t;

  // Classes whose second ALU operand is the sign-extended immediate.
  function automatic logic uses_imm(cls_e c);
    return (c == CLS_IALU) || (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

  // Classes that go through the data-memory step.
  function automatic logic is_mem(cls_e c);
    return (c == CLS_LOAD) || (c == CLS_STORE);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier.
//   opcode/funct3/funct7 : fields of the latched instruction
//   dec                  : {class, ALU op}; LOAD/STORE always use add
//   illegal              : unknown opcode or unsupported funct combination
module mc_decode
  import mc_pkg::*;
#(
  parameter int OPC_W = 7
) (
  input  logic [OPC_W-1:0] opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  output dec_t             dec,
  output logic             illegal
);

  always_comb begin
    dec.cls    = CLS_ILLEGAL;
    dec.alu_op = ALU_ADD;
    case (opcode)
      OPC_RTYPE: begin
        case ({funct7, funct3})
          {7'b0000000, 3'b000}: begin dec.cls = CLS_RTYPE; dec.alu_op = ALU_ADD; end
          {7'b0100000, 3'b000}: begin dec.cls = CLS_RTYPE; dec.alu_op = ALU_SUB; end
          {7'b0000000, 3'b111}: begin dec.cls = CLS_RTYPE; dec.alu_op = ALU_AND; end
          {7'b0000000, 3'b110}: begin dec.cls = CLS_RTYPE; dec.alu_op = ALU_OR;  end
          default: ;
        endcase
      end
      OPC_IALU: begin
        // funct7 carries immediate bits here, so it plays no part in the op.
        case (funct3)
          3'b000:  begin dec.cls = CLS_IALU; dec.alu_op = ALU_ADD; end
          3'b111:  begin dec.cls = CLS_IALU; dec.alu_op = ALU_AND; end
          3'b110:  begin dec.cls = CLS_IALU; dec.alu_op = ALU_OR;  end
          default: ;
        endcase
      end
      OPC_LOAD:  dec.cls = CLS_LOAD;
      OPC_STORE: dec.cls = CLS_STORE;
      default: ;
    endcase
    illegal = (dec.cls == CLS_ILLEGAL);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I-subset datapath. Steps each
// instruction through FETCH/DECODE/EXEC/[MEM]/[WB] and drives the datapath
// strobes one step at a time.
//
// Ports:
//   clk, rst          : rising-edge clock, async active-high reset
//   run               : start request, looked at only in IDLE
//   opcode/funct3/7   : fields of the latched instruction (valid from DECODE)
//   mem_ready         : data memory completes the current request
//   ir_write          : latch instruction register (FETCH)
//   pc_write          : pc <= pc+4, once per retired instruction
//   reg_write         : register file write (WB)
//   alu_src           : 0 = rs2, 1 = sign-extended immediate
//   alu_control       : 00 add, 01 sub, 10 and, 11 or
//   mem_req/mem_write : data memory request, qualified store/load
//   mem_to_reg        : writeback source, 1 = memory
//   halted            : sticky illegal-instruction flag
//   state_o           : current state for debug
//   retired           : retired-instruction counter (MC_RETIRE_CNT_EN only)
//
// Build option: define MC_RETIRE_CNT_EN to add the `retired` output and its
// RETIRE_W-bit wrapping counter.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int OPC_W    = 7,
  parameter int RETIRE_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [OPC_W-1:0] opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             alu_src,
  output logic [1:0]       alu_control,
  output logic             mem_req,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic [2:0]       state_o
`ifdef MC_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] retired
`endif
);

  if (RETIRE_W < 1) begin : g_bad_retire_w
    $error("multicycle_ctrl: RETIRE_W must be at least 1");
  end

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  logic [1:0] op_q, op_d;

  dec_t dec;
  logic dec_illegal;

  mc_decode #(.OPC_W(OPC_W)) u_decode (
    .opcode  (opcode),
    .funct3  (funct3),
    .funct7  (funct7),
    .dec     (dec),
    .illegal (dec_illegal)
  );

  // Registered output flops.
  logic       ir_write_q,    ir_write_d;
  logic       pc_wb_q,       pc_wb_d;
  logic       reg_write_q,   reg_write_d;
  logic       alu_src_q,     alu_src_d;
  logic [1:0] alu_control_q, alu_control_d;
  logic       mem_req_q,     mem_req_d;
  logic       mem_write_q,   mem_write_d;
  logic       mem_to_reg_q,  mem_to_reg_d;
  logic       halted_q,      halted_d;
  logic       alu_phase;
  logic       store_done;

  // Next state and latched decode.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE:   if (run) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        cls_d   = dec.cls;
        op_d    = dec.alu_op;
        state_d = dec_illegal ? ST_HALT : ST_EXEC;
      end
      ST_EXEC:   state_d = is_mem(cls_q) ? ST_MEM : ST_WB;
      ST_MEM: begin
        if (mem_ready) state_d = (cls_q == CLS_STORE) ? ST_FETCH : ST_WB;
      end
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so the flops present
  // them during that state (Moore behaviour with registered outputs).
  always_comb begin
    alu_phase     = (state_d == ST_EXEC) || (state_d == ST_MEM) || (state_d == ST_WB);
    ir_write_d    = (state_d == ST_FETCH);
    pc_wb_d       = (state_d == ST_WB);
    reg_write_d   = (state_d == ST_WB);
    mem_to_reg_d  = (state_d == ST_WB) && (cls_d == CLS_LOAD);
    mem_req_d     = (state_d == ST_MEM);
    mem_write_d   = (state_d == ST_MEM) && (cls_d == CLS_STORE);
    halted_d      = (state_d == ST_HALT);
    alu_src_d     = alu_phase && uses_imm(cls_d);
    alu_control_d = alu_phase ? op_d : ALU_ADD;
  end

  // A store retires in the MEM cycle that mem_ready arrives, so the pc must
  // advance on that same edge; this term cannot be known a cycle early and
  // is therefore combined from the registered state and mem_ready.
  assign store_done = (state_q == ST_MEM) && (cls_q == CLS_STORE) && mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cls_q         <= CLS_RTYPE;
      op_q          <= ALU_ADD;
      ir_write_q    <= 1'b0;
      pc_wb_q       <= 1'b0;
      reg_write_q   <= 1'b0;
      alu_src_q     <= 1'b0;
      alu_control_q <= ALU_ADD;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cls_q         <= cls_d;
      op_q          <= op_d;
      ir_write_q    <= ir_write_d;
      pc_wb_q       <= pc_wb_d;
      reg_write_q   <= reg_write_d;
      alu_src_q     <= alu_src_d;
      alu_control_q <= alu_control_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      halted_q      <= halted_d;
    end
  end

  assign ir_write    = ir_write_q;
  assign pc_write    = pc_wb_q | store_done;
  assign reg_write   = reg_write_q;
  assign alu_src     = alu_src_q;
  assign alu_control = alu_control_q;
  assign mem_req     = mem_req_q;
  assign mem_write   = mem_write_q;
  assign mem_to_reg  = mem_to_reg_q;
  assign halted      = halted_q;
  assign state_o     = state_q;

`ifdef MC_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retired_q, retired_d;

  // pc_write is never asserted in HALT, so the count freezes there.
  always_comb begin
    retired_d = retired_q;
    if (pc_write) retired_d = retired_q + RETIRE_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retired_q <= '0;
    else     retired_q <= retired_d;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_multicycle_ctrl;

`ifdef MC_RETIRE_CNT_EN
  localparam int RW = 4;
`else
  localparam int RW = 32;
`endif

  logic       clk = 1'b0;
  logic       rst, run, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       ir_write, pc_write, reg_write, alu_src, mem_req, mem_write, mem_to_reg, halted;
  logic [1:0] alu_control;
  logic [2:0] state_o;
`ifdef MC_RETIRE_CNT_EN
  logic [RW-1:0] retired;
`endif

  multicycle_ctrl #(.OPC_W(7), .RETIRE_W(RW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src(alu_src), .alu_control(alu_control), .mem_req(mem_req), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .halted(halted), .state_o(state_o)
`ifdef MC_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; int n; } instr_t;
  typedef struct { bit halt; int cycles; logic [1:0] alu; logic src; int mreq; int mwr; int rw; logic m2r; } exp_t;

  instr_t plan_q[$];
  exp_t   exp_q[$];
  int     n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Instruction-level reference: what one instruction should look like on
  // the control outputs, straight from the ISA subset tables.
  function automatic exp_t model(input instr_t i);
    exp_t e;
    e.halt = 0; e.alu = 2'b00; e.src = 0; e.mreq = 0; e.mwr = 0; e.rw = 1; e.m2r = 0; e.cycles = 4;
    case (i.opc)
      7'b0110011: begin
        if      (i.f3 == 3'b000 && i.f7 == 7'b0000000) e.alu = 2'b00;
        else if (i.f3 == 3'b000 && i.f7 == 7'b0100000) e.alu = 2'b01;
        else if (i.f3 == 3'b111 && i.f7 == 7'b0000000) e.alu = 2'b10;
        else if (i.f3 == 3'b110 && i.f7 == 7'b0000000) e.alu = 2'b11;
        else e.halt = 1;
      end
      7'b0010011: begin
        e.src = 1;
        if      (i.f3 == 3'b000) e.alu = 2'b00;
        else if (i.f3 == 3'b111) e.alu = 2'b10;
        else if (i.f3 == 3'b110) e.alu = 2'b11;
        else e.halt = 1;
      end
      7'b0000011: begin e.src = 1; e.mreq = i.n; e.m2r = 1; e.cycles = 4 + i.n; end
      7'b0100011: begin e.src = 1; e.mreq = i.n; e.mwr = i.n; e.rw = 0; e.cycles = 3 + i.n; end
      default: e.halt = 1;
    endcase
    if (e.halt) e.cycles = 3;  // FETCH, DECODE, then HALT visible
    return e;
  endfunction

  function automatic instr_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7, input int n);
    instr_t i;
    i.opc = opc; i.f3 = f3; i.f7 = f7; i.n = n;
    return i;
  endfunction

  function automatic instr_t rand_legal();
    instr_t i;
    int k;
    logic [2:0] f3s [3];
    f3s[0] = 3'b000; f3s[1] = 3'b111; f3s[2] = 3'b110;
    i = mk(7'b0, 3'($urandom), 7'($urandom), $urandom_range(1, 4));
    k = $urandom_range(0, 3);
    case (k)
      0: begin
        i.opc = 7'b0110011;
        i.f3 = f3s[$urandom_range(0, 2)];
        i.f7 = 7'b0;
        if (i.f3 == 3'b000 && $urandom_range(0, 1) == 1) i.f7 = 7'b0100000;
      end
      1: begin i.opc = 7'b0010011; i.f3 = f3s[$urandom_range(0, 2)]; end
      2: i.opc = 7'b0000011;
      default: i.opc = 7'b0100011;
    endcase
    return i;
  endfunction

  // Driver: supplies the instruction when FETCH is seen, answers memory
  // requests after the planned number of MEM cycles, and scribbles on
  // mem_ready whenever it should be ignored.
  initial begin : driver
    instr_t cur;
    int mcnt;
    cur = mk(7'b0, 3'b0, 7'b0, 1);
    mcnt = 0;
    opcode = 7'b0; funct3 = 3'b0; funct7 = 7'b0; mem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (state_o == 3'd1 && !rst) begin
        if (plan_q.size() > 0) cur = plan_q.pop_front();
        else cur = rand_legal();
        opcode = cur.opc; funct3 = cur.f3; funct7 = cur.f7;
        exp_q.push_back(model(cur));
        mcnt = 0;
      end
      if (state_o == 3'd4) begin
        mem_ready = (mcnt == cur.n - 1);
        mcnt++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: rebuilds each instruction window from the outputs and checks
  // it against the scoreboard when the instruction retires or halts.
  initial begin : monitor
    bit win, halt_seen;
    int cyc, mreq, mwr, rw, nret;
    logic [1:0] alu;
    logic src, m2r, hold_ok;
    exp_t e;
    win = 0; halt_seen = 0; cyc = 0; mreq = 0; mwr = 0; rw = 0; nret = 0;
    alu = 2'b0; src = 0; m2r = 0; hold_ok = 1;
    forever begin
      @(negedge clk);
      if (rst) begin win = 0; halt_seen = 0; nret = 0; continue; end
      if (ir_write) begin
        win = 1; cyc = 0; mreq = 0; mwr = 0; rw = 0; m2r = 0; hold_ok = 1; alu = 2'b0; src = 0;
      end
      if (win) begin
        cyc++;
        if (state_o == 3'd3) begin alu = alu_control; src = alu_src; end
        else if (state_o == 3'd4 || state_o == 3'd5) begin
          if (alu_control !== alu || alu_src !== src) hold_ok = 0;
        end
        if (mem_req)   mreq++;
        if (mem_write) mwr++;
        if (reg_write) begin rw++; m2r = mem_to_reg; end
        if (pc_write) begin
          win = 0;
          if (exp_q.size() == 0) chk("retire_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("retire_not_halt", 0, 32'(e.halt));
            chk("latency",         cyc, e.cycles);
            chk("alu_control",     32'(alu), 32'(e.alu));
            chk("alu_src",         32'(src), 32'(e.src));
            chk("mem_req_cycles",  mreq, e.mreq);
            chk("mem_write_cycles", mwr, e.mwr);
            chk("reg_write_count", rw, e.rw);
            if (e.rw != 0) chk("mem_to_reg", 32'(m2r), 32'(e.m2r));
            chk("alu_hold", 32'(hold_ok), 1);
`ifdef MC_RETIRE_CNT_EN
            chk("retired", 32'(retired), 32'(nret % (1 << RW)));
`endif
            nret++;
          end
        end else if (halted) begin
          win = 0; halt_seen = 1;
          if (exp_q.size() == 0) chk("halt_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("halt_expected", 1, 32'(e.halt));
            chk("halt_latency", cyc, e.cycles);
          end
        end
      end else if (pc_write) begin
        chk("pc_write_stray", 1, 0);
      end
      if (halt_seen) begin
        chk("halt_sticky", {29'b0, halted, state_o == 3'd6, 1'b1}, 32'b111);
        chk("halt_strobes", {26'b0, ir_write, pc_write, reg_write, mem_req, mem_write, mem_to_reg}, 0);
      end
    end
  end

  task automatic wait_halt(input int budget);
    int c;
    c = 0;
    while (!halted && c < budget) begin
      @(negedge clk);
      run = 1'($urandom_range(0, 1));  // run is irrelevant once started
      c++;
    end
    chk("halt_reached", 32'(halted), 1);
  endtask

  function automatic logic [31:0] all_outs();
    return {20'b0, ir_write, pc_write, reg_write, alu_src, alu_control, mem_req, mem_write,
            mem_to_reg, halted, state_o[1:0]} | {29'b0, state_o};
  endfunction

  initial begin : main
    int c;
    rst = 1'b1; run = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", 32'(state_o), 0);
    chk("reset_outputs", all_outs(), 0);
`ifdef MC_RETIRE_CNT_EN
    chk("reset_retired", 32'(retired), 0);
`endif
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_without_run", 32'(state_o), 0);

    // Phase 1: directed SUB, slow LOAD, fast STORE, random stream, illegal opcode.
    plan_q.push_back(mk(7'b0110011, 3'b000, 7'b0100000, 1));
    plan_q.push_back(mk(7'b0000011, 3'b010, 7'b0, 4));
    plan_q.push_back(mk(7'b0100011, 3'b010, 7'b0, 1));
    for (int i = 0; i < 30; i++) plan_q.push_back(rand_legal());
    plan_q.push_back(mk(7'b1101111, 3'b000, 7'b0, 1));
    run = 1'b1;
    wait_halt(2000);
    // Halt is sticky: toggle run for a while, monitor checks each cycle.
    repeat (8) begin @(negedge clk); run = 1'($urandom_range(0, 1)); end

    // Phase 2: reset in the middle of a memory wait.
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; run = 1'b0;
    exp_q.delete(); plan_q.delete();
    plan_q.push_back(mk(7'b0000011, 3'b010, 7'b0, 20));
    @(negedge clk); run = 1'b1;
    c = 0;
    while (state_o != 3'd4 && c < 50) begin @(negedge clk); c++; end
    chk("reached_mem", 32'(state_o), 4);
    @(posedge clk); #1;
    chk("mem_req_before_abort", 32'(mem_req), 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_mem_req", 32'(mem_req), 0);
    chk("abort_state", 32'(state_o), 0);
    chk("abort_outputs", all_outs(), 0);
    exp_q.delete(); plan_q.delete();

    // Phase 3: 17 back-to-back ADDIs then an unsupported R-type funct3.
    @(negedge clk); rst = 1'b0; run = 1'b0;
    for (int i = 0; i < 17; i++) plan_q.push_back(mk(7'b0010011, 3'b000, 7'($urandom), 1));
    plan_q.push_back(mk(7'b0110011, 3'b001, 7'b0, 1));
    @(negedge clk); run = 1'b1;
    wait_halt(500);
    repeat (4) @(negedge clk);
`ifdef MC_RETIRE_CNT_EN
    chk("retired_wrap", 32'(retired), 32'(17 % (1 << RW)));
`endif
    chk("scoreboard_drained", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    chk("final_reset_state", 32'(state_o), 0);
`ifdef MC_RETIRE_CNT_EN
    chk("final_reset_retired", 32'(retired), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I-subset datapath: pc register, instruction memory, register file, 2-bit-op ALU, data memory.
- Breaks each instruction into FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps.
- Drives the datapath write enables and ALU selects one step at a time.
- Handshakes with a data memory that may take several cycles (req/ready).

Parameters:
- OPC_W, 7, opcode field width
- RETIRE_W, 32, retire counter width (used only with the optional feature)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- run  input  1  1 = leave IDLE and execute; sampled only in IDLE
- opcode  input  7  instruction[6:0], valid from DECODE onward (IR latched)
- funct3  input  3  instruction[14:12]
- funct7  input  7  instruction[31:25]
- mem_ready  input  1  data memory completes the current request this cycle
- ir_write  output  1  latch the instruction register
- pc_write  output  1  pc <= pc+4
- reg_write  output  1  register file write strobe
- alu_src  output  1  0 = rs2, 1 = sign-extended imm
- alu_control  output  2  00 add, 01 sub, 10 and, 11 or
- mem_req  output  1  data memory request
- mem_write  output  1  qualifies mem_req: 1 = store, 0 = load
- mem_to_reg  output  1  writeback source: 1 = memory, 0 = ALU result
- halted  output  1  sticky illegal-instruction flag
- state_o  output  3  current state, for debug

Behaviour:
- Reset (async, rst=1): state IDLE; every output 0; alu_control 00; state_o = IDLE.
- Reset mid-operation aborts immediately. Any pending mem_req drops the same instant.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- All outputs are registered Moore outputs, decoded from state plus the latched decode class.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH (1 cycle): ir_write=1 -> DECODE.
- DECODE (1 cycle), classify opcode:
  - 0110011 R-type
  - 0010011 I-ALU
  - 0000011 LOAD
  - 0100011 STORE
  - anything else ILLEGAL
- ALU op from funct3/funct7:
  - R-type: 000/0000000 add; 000/0100000 sub; 111/0000000 and; 110/0000000 or.
  - I-ALU: 000 add; 111 and; 110 or; funct7 ignored.
  - Any other combination is ILLEGAL.
  - Class and ALU op are latched in DECODE.
- DECODE transitions: ILLEGAL -> HALT; otherwise -> EXEC.
- EXEC (1 cycle): alu_control = latched op (add for LOAD/STORE); alu_src = 1 for I-ALU/LOAD/STORE, else 0.
  - R/I-ALU -> WB
  - LOAD/STORE -> MEM
- alu_src/alu_control hold their values through MEM and WB.
- MEM: mem_req=1, mem_write = (STORE).
  - Held stable until mem_ready=1. No timeout.
  - mem_ready outside MEM is ignored.
  - mem_ready=1 in the first MEM cycle completes the access that cycle.
  - On completion: STORE -> FETCH with pc_write=1 in that cycle's transition; LOAD -> WB.
- WB (1 cycle): reg_write=1; mem_to_reg = (LOAD); pc_write=1 -> FETCH.
- pc_write is asserted exactly once per retired instruction, on the final step.
- Latency: R/I = 4 cycles (FETCH, DECODE, EXEC, WB); STORE = 3 + n; LOAD = 4 + n (n = MEM cycles ≥ 1).
- HALT: halted=1, all strobes 0, sticky until rst. run is ignored.
- run=0 mid-instruction has no effect; it is checked only in IDLE. After the first run, the FSM loops FETCH→… continuously.

Optional Feature:
- Macro MC_RETIRE_CNT_EN.
- Defined:
  - Adds output port retired [RETIRE_W-1:0].
  - Increments on every pc_write and wraps modulo 2^RETIRE_W.
  - Reset 0. Does not count in HALT.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package mc_pkg:
  - State enum
  - Opcode constants OPC_RTYPE/OPC_IALU/OPC_LOAD/OPC_STORE
  - ALU op constants ALU_ADD/SUB/AND/OR
  - Decode-class enum
- Sub-module mc_decode: combinational opcode/funct3/funct7 -> {class, alu op, illegal}. The FSM registers its outputs in DECODE.

Test Plan:
- rst=1 pulsed mid-MEM with mem_req=1 -> mem_req drops asynchronously; state_o=0 and all outputs 0 before the next edge.
- run=1, opcode=0110011, funct3=000, funct7=0100000 -> states 1,2,3,5; alu_control=01, alu_src=0 in EXEC; reg_write=1 and pc_write=1 in WB; back to FETCH.
- LOAD (0000011), mem_ready low 3 cycles then high -> mem_req=1 and mem_write=0 for 4 cycles; WB with mem_to_reg=1, reg_write=1; total 8 cycles.
- STORE (0100011), mem_ready=1 in the first MEM cycle -> mem_write=1 for 1 cycle; reg_write never 1; pc_write=1; total 4 cycles.
- opcode=1101111, or R-type funct3=001 -> HALT; halted=1 held; run toggling and mem_ready ignored until rst.
- With MC_RETIRE_CNT_EN, RETIRE_W=4: 17 back-to-back ADDIs -> retired=1 (wrap); after rst, retired=0.
